// File: rtl/sam_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the legal operand-width range.
package sam_pkg;

  typedef enum logic {
    SAM_IDLE = 1'b0,
    SAM_RUN  = 1'b1
  } sam_state_e;

  localparam int SAM_MIN_WIDTH = 2;
  localparam int SAM_MAX_WIDTH = 32;

  // True when an operand width lies in the supported range.
  function automatic bit sam_width_ok(input int w);
    return (w >= SAM_MIN_WIDTH) && (w <= SAM_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/sam_add_shift_step.sv
// One shift-and-add step: conditionally add the multiplicand into the
// upper half, then shift {carry, P, Q} right by one bit.
module sam_add_shift_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] p_next,
  output logic [WIDTH-1:0] q_next
);

  // Sum is one bit wider than P so the carry is never lost.
  logic [WIDTH:0] sum;

  assign sum    = {1'b0, p} + (q[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign p_next = sum[WIDTH:1];
  assign q_next = {sum[0], q[WIDTH-1:1]};

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier with a
// start/busy/done handshake; one partial-product step per clock.
// Optional feature macro: SAM_SIGNED_EN adds an is_signed input that
// treats a and b as two's complement (magnitudes through the core,
// sign applied to the registered product).
module seq_shift_add_multiplier
  import sam_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SAM_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  if (!sam_width_ok(WIDTH)) begin : g_bad_width
    $error("seq_shift_add_multiplier: WIDTH out of range 2..32");
  end

  sam_state_e         state;
  logic [WIDTH-1:0]   p;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   p_next;
  logic [WIDTH-1:0]   q_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_final;

  assign prod_raw = {p_next, q_next};

`ifdef SAM_SIGNED_EN
  logic neg_a;
  logic neg_b;
  logic sign_r;

  // Magnitudes of negative operands; the most-negative value maps to
  // 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  assign neg_a      = is_signed & a[WIDTH-1];
  assign neg_b      = is_signed & b[WIDTH-1];
  assign a_mag      = neg_a ? -a : a;
  assign b_mag      = neg_b ? -b : b;
  assign prod_final = sign_r ? -prod_raw : prod_raw;
`else
  assign a_mag      = a;
  assign b_mag      = b;
  assign prod_final = prod_raw;
`endif

  sam_add_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p      (p),
    .q      (q),
    .m      (m),
    .p_next (p_next),
    .q_next (q_next)
  );

  // Control FSM, step counter, operand capture and registered outputs.
  // NOTE: non-blocking assignments keep every register updating from
  // pre-edge values, so the step datapath sees a consistent P/Q/M.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so product and the
      // internal P/Q/M state read as zero straight after reset.
      state   <= SAM_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      p       <= '0;
      q       <= '0;
      m       <= '0;
      count   <= '0;
`ifdef SAM_SIGNED_EN
      sign_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        SAM_IDLE: begin
          if (start) begin
            m      <= a_mag;
            q      <= b_mag;
            p      <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= SAM_RUN;
`ifdef SAM_SIGNED_EN
            sign_r <= neg_a ^ neg_b;
`endif
          end
        end
        SAM_RUN: begin
          p     <= p_next;
          q     <= q_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            product <= prod_final;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= SAM_IDLE;
          end
        end
        default: state <= SAM_IDLE;
      endcase
    end
  end

endmodule
